// File: rtl/multicycle_mem_arbiter.sv
// rtl/multicycle_mem_arbiter.sv - two-port round-robin arbiter for a single-port variable-latency memory
module multicycle_mem_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [3:0]  wmask0,
  output logic        ready0,
  output logic [31:0] rdata0,
  output logic        err0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  input  logic [3:0]  wmask1,
  output logic        ready1,
  output logic [31:0] rdata1,
  output logic        err1,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Count value seen on the last permitted BUSY cycle; only meaningful when TIMEOUT is nonzero.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_t            state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        wmask_q;

  logic              any_req;
  logic              grant_port;
  logic              timeout_hit;
  logic              done;
  logic              done_err;

  // Round-robin choice: a lone requester wins outright, a tie goes to the port not served last.
  always_comb begin
    any_req    = req0 | req1;
    grant_port = 1'b0;
    if (req0 && req1) begin
      grant_port = ~last_grant_q;
    end else if (req1) begin
      grant_port = 1'b1;
    end
    timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  end

  // Next-state and completion decode; an ack always beats a simultaneous timeout.
  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    done_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done    = 1'b1;
          state_d = IDLE;
        end else if (timeout_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops back to IDLE immediately, aborting any access in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant bookkeeping and the latched copy of the granted request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
    end else if (state_q == IDLE && any_req) begin
      owner_q      <= grant_port;
      last_grant_q <= grant_port;
      we_q         <= grant_port ? we1 : we0;
      addr_q       <= grant_port ? addr1 : addr0;
      wdata_q      <= grant_port ? wdata1 : wdata0;
      wmask_q      <= grant_port ? wmask1 : wmask0;
    end
  end

  // Wait-cycle counter: cleared on grant, advances each BUSY cycle, parks at all-ones.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Memory side and per-port completion outputs; the non-owner sees all zeros.
  always_comb begin
    mem_req   = (state_q == BUSY);
    busy      = (state_q == BUSY);
    mem_we    = we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_wmask = wmask_q;
    ready0    = done & ~owner_q;
    ready1    = done & owner_q;
    err0      = done_err & ~owner_q;
    err1      = done_err & owner_q;
    rdata0    = (ready0 && !done_err) ? mem_rdata : 32'h0;
    rdata1    = (ready1 && !done_err) ? mem_rdata : 32'h0;
  end

endmodule
